ibex_efpga_responder: RTL
=========================

Name: ibex_efpga_responder

Overview:
Fabric-side endpoint of the custom-instruction (CX) path. It accepts one request from the EX stage over a valid/ready handshake and drives operands and a start pulse into the eFPGA fabric. It then completes the request in one of two ways: after a programmed fixed delay, or on a fabric done strobe with a timeout. The captured result goes back over a valid/ready response channel. It sits between the core's eFPGA unit and the reconfigurable fabric, one outstanding transaction at a time.

Parameters:
DATA_WIDTH, 32, operand/result width
DELAY_WIDTH, 4, width of fixed-delay field
TIMEOUT_CYCLES, 255, WAIT cycles allowed in handshake mode before error (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  responder can accept
req_optype_i  in  2  cx op type
req_operand_a_i  in  DATA_WIDTH  operand A
req_operand_b_i  in  DATA_WIDTH  operand B
req_delay_i  in  DELAY_WIDTH  fixed-mode delay
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  core accepts response
rsp_result_o  out  DATA_WIDTH  result
rsp_err_o  out  1  timeout/reserved-op error
flush_i  in  1  core kill, abort transaction
fabric_start_o  out  1  one-cycle start pulse
fabric_optype_o  out  2  latched op type
fabric_operand_a_o  out  DATA_WIDTH  latched operand A
fabric_operand_b_o  out  DATA_WIDTH  latched operand B
fabric_result_i  in  DATA_WIDTH  fabric result
fabric_done_i  in  1  fabric completion strobe
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, START, WAIT, RESP. Reset: IDLE, all registers 0; rsp_valid_o=0, rsp_err_o=0, rsp_result_o=0, fabric_start_o=0, fabric_* operands/optype=0, busy_o=0, req_ready_o=1.
- req_ready_o = (state==IDLE) & ~flush_i. Accept when req_valid_i & req_ready_o. The accept latches operands, optype and delay. fabric_* outputs come from these latches and stay stable until the next accept.
- Optype 00 FIXED, 01 HSHAKE, 10 COMB, 11 RSVD.
- IDLE->START on accept for FIXED/HSHAKE/COMB. For RSVD: IDLE->RESP directly, no start pulse, err=1, result=0.
- START: fabric_start_o=1 for exactly this cycle. Wait counter loads delay (FIXED), 0 (COMB), or 0 as up-count (HSHAKE). START->WAIT.
- WAIT FIXED/COMB: if cnt==0, capture fabric_result_i, go RESP, err=0; else decrement cnt.
- WAIT HSHAKE: if fabric_done_i, capture fabric_result_i, go RESP, err=0. Else if cnt==TIMEOUT_CYCLES-1, go RESP with err=1, result=0. Else cnt++. A done during START is ignored.
- Latency, with accept in cycle N: FIXED captures in N+2+delay and rsp_valid_o rises in N+3+delay. COMB gives rsp_valid_o in N+3. HSHAKE with done in cycle D>=N+2 gives rsp_valid_o in D+1. Timeout gives rsp_valid_o in N+2+TIMEOUT_CYCLES.
- RESP: rsp_valid_o=1. Result and err are held stable until rsp_ready_i; on handshake, go IDLE. The next accept happens no earlier than the cycle after the handshake.
- flush_i has priority in every state except IDLE. Next state is IDLE, no response is produced, and pending counter/result are discarded. In START, the pulse still asserts that cycle; the fabric must tolerate an aborted start. A fabric_done_i arriving after flush is ignored.
- An asynchronous reset mid-transaction returns to reset values immediately, with no response.
- Counter width: max(DELAY_WIDTH, clog2(TIMEOUT_CYCLES)). No wrap: the terminal check precedes the decrement/increment.

Decomposition:
- ibex_defines gains cx_op_e (CX_FIXED=2'b00, CX_HSHAKE=2'b01, CX_COMB=2'b10, CX_RSVD=2'b11) and efpga_rsp_state_e (IDLE, START, WAIT, RESP).
- One sub-module: ibex_efpga_wait_ctr, a loadable up/down counter with a terminal-count flag compared against a load value or TIMEOUT_CYCLES-1.

Test Plan:
- FIXED, delay=3, req at cycle 0, a=0x00001234, b=0x00005678, fabric_result=0xDEADBEEF, rsp_ready=1 -> fabric_start only in cycle 1; rsp_valid in cycle 6 with result 0xDEADBEEF, err 0; req_ready back in cycle 7.
- COMB and FIXED delay=0 -> rsp_valid in cycle 3 in both cases; fabric_operand_a_o=0x00001234 held from cycle 1 until the next accept.
- HSHAKE, done at cycle 7 with 0xCAFEF00D, rsp_ready low for cycles 8-11 -> rsp_valid stays high from cycle 8 with a stable result; req_ready=0 and a second req_valid is not accepted; accept occurs in cycle 13 after the handshake in cycle 12.
- HSHAKE, TIMEOUT_CYCLES=16, no done -> rsp_valid in cycle 18, err=1, result 0; a later done is ignored.
- RSVD optype -> no fabric_start; rsp_valid in cycle 1, err=1, result 0.
- flush_i in cycle 4 during a FIXED delay=8 transaction -> IDLE in cycle 5, rsp_valid never rises, a new request is accepted in cycle 5. rst_n low mid-WAIT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ibex_efpga_responder_pkg.sv
// Shared types for the eFPGA custom-instruction (CX) responder.
package ibex_efpga_responder_pkg;

  typedef enum logic [1:0] {
    CX_FIXED  = 2'b00,
    CX_HSHAKE = 2'b01,
    CX_COMB   = 2'b10,
    CX_RSVD   = 2'b11
  } cx_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } efpga_rsp_state_e;

  // Wide enough for the largest fixed delay and for the handshake timeout limit.
  function automatic int unsigned cx_cnt_width(input int unsigned delay_w,
                                               input int unsigned timeout);
    int unsigned t_w;
    t_w = (timeout > 1) ? $clog2(timeout) : 1;
    return (delay_w > t_w) ? delay_w : t_w;
  endfunction

endpackage

// File: rtl/ibex_efpga_wait_ctr.sv
// Loadable up/down wait counter; tc flags 0 when counting down, TIMEOUT_CYCLES-1 when counting up.
// Holds at the terminal value: the terminal check gates every step.
module ibex_efpga_wait_ctr #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_up,
  input  logic             step,
  output logic             tc
);

  localparam logic [WIDTH-1:0] UP_LIMIT = WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] cnt_q;
  logic             up_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      up_q  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      up_q  <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      up_q  <= count_up;
    end else if (step && !tc) begin
      cnt_q <= up_q ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  assign tc = up_q ? (cnt_q == UP_LIMIT) : (cnt_q == '0);

endmodule

// File: rtl/ibex_efpga_responder.sv
// Fabric-side CX endpoint: one outstanding request, start pulse, fixed-delay or done/timeout completion.
// Response in 3+delay cycles (fixed/comb) or done+1; req_ready low until the response handshakes.
module ibex_efpga_responder
  import ibex_efpga_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DELAY_WIDTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_optype_i,
  input  logic [DATA_WIDTH-1:0]  req_operand_a_i,
  input  logic [DATA_WIDTH-1:0]  req_operand_b_i,
  input  logic [DELAY_WIDTH-1:0] req_delay_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_result_o,
  output logic                   rsp_err_o,
  input  logic                   flush_i,
  output logic                   fabric_start_o,
  output logic [1:0]             fabric_optype_o,
  output logic [DATA_WIDTH-1:0]  fabric_operand_a_o,
  output logic [DATA_WIDTH-1:0]  fabric_operand_b_o,
  input  logic [DATA_WIDTH-1:0]  fabric_result_i,
  input  logic                   fabric_done_i,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = cx_cnt_width(DELAY_WIDTH, TIMEOUT_CYCLES);

  efpga_rsp_state_e        state_q, state_d;
  cx_op_e                  op_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, res_q, res_d;
  logic [DELAY_WIDTH-1:0]  delay_q;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    ctr_clear, ctr_load, ctr_tc;
  logic [CNT_W-1:0]        ctr_load_val;

  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

  // Operand latches feed the fabric directly and only change on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= CX_FIXED;
      a_q     <= '0;
      b_q     <= '0;
      delay_q <= '0;
    end else if (accept) begin
      op_q    <= cx_op_e'(req_optype_i);
      a_q     <= req_operand_a_i;
      b_q     <= req_operand_b_i;
      delay_q <= req_delay_i;
    end
  end

  assign ctr_load_val = (op_q == CX_FIXED) ? CNT_W'(delay_q) : '0;

  ibex_efpga_wait_ctr #(
    .WIDTH          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .count_up (op_q == CX_HSHAKE),
    .step     (state_q == WAIT),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    err_d     = err_q;
    ctr_clear = 1'b0;
    ctr_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cx_op_e'(req_optype_i) == CX_RSVD) begin
            state_d = RESP;
            res_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        state_d  = WAIT;
        ctr_load = 1'b1;
      end
      WAIT: begin
        if (op_q == CX_HSHAKE) begin
          if (fabric_done_i) begin
            state_d = RESP;
            res_d   = fabric_result_i;
            err_d   = 1'b0;
          end else if (ctr_tc) begin
            state_d = RESP;
            res_d   = '0;
            err_d   = 1'b1;
          end
        end else if (ctr_tc) begin
          state_d = RESP;
          res_d   = fabric_result_i;
          err_d   = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
    endcase
    // Abort wins over any completion in the same cycle; nothing of the transaction survives.
    if (flush_i && state_q != IDLE) begin
      state_d   = IDLE;
      res_d     = '0;
      err_d     = 1'b0;
      ctr_clear = 1'b1;
      ctr_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_o        = (state_q == RESP);
  assign rsp_result_o       = res_q;
  assign rsp_err_o          = err_q;
  assign fabric_start_o     = (state_q == START);
  assign fabric_optype_o    = op_q;
  assign fabric_operand_a_o = a_q;
  assign fabric_operand_b_o = b_q;
  assign busy_o             = (state_q != IDLE);

endmodule
